// File: rtl/arith_op_arbiter_pkg.sv
// Shared definitions for the arithmetic-unit arbiter slice.
// Contents:
//   OP_*     3-bit opselect codes understood by the arithmetic unit
//   state_t  arbiter FSM states (IDLE -> EXEC -> RESP -> IDLE)
package arith_op_arbiter_pkg;

  localparam logic [2:0] OP_PASSA = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUBAB = 3'd2;
  localparam logic [2:0] OP_SUBBA = 3'd3;
  localparam logic [2:0] OP_NEGA  = 3'd4;
  localparam logic [2:0] OP_INCA  = 3'd5;
  localparam logic [2:0] OP_SUBA3 = 3'd6;
  localparam logic [2:0] OP_ADDB2 = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/arith_op_arbiter_if.sv
// Request/response bus between the operand sources and the shared arithmetic unit.
// Signals:
//   req_valid   per-requester request valid
//   req_ready   per-requester accept strobe (one-hot or zero)
//   req_op      opselect per requester, slice i = [3i+2:3i]
//   req_a/req_b operands per requester, slice i = [8i+7:8i]
//   resp_valid  response valid
//   resp_ready  downstream accepts the response
//   resp_id     index of the requester owning the response
//   resp_result 8-bit result
// Modports: master = requesters/consumer side, slave = arbiter side.
interface arith_op_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [7:0]           resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result
  );

endinterface

// File: rtl/arith_op_arbiter_alu.sv
// Existing combinational 8-bit arithmetic unit, all results modulo 256.
// Ports:
//   opselect  in  3  operation code (see OP_* in the package)
//   a, b      in  8  operands
//   result    out 8  operation result
module arith_op_arbiter_alu
  import arith_op_arbiter_pkg::*;
(
  input  logic [2:0] opselect,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  // One arm per opcode; 8-bit arithmetic wraps naturally.
  always_comb begin
    result = 8'h00;
    case (opselect)
      OP_PASSA: result = a;
      OP_ADD:   result = a + b;
      OP_SUBAB: result = a - b;
      OP_SUBBA: result = b - a;
      OP_NEGA:  result = 8'h00 - a;
      OP_INCA:  result = a + 8'h01;
      OP_SUBA3: result = a - 8'h03;
      OP_ADDB2: result = b + 8'h02;
      default:  result = 8'h00;
    endcase
  end

endmodule

// File: rtl/arith_op_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward from
// last_grant+1 with wrap, so the last winner has the lowest priority.
// Ports:
//   req         in   NUM_REQ  request vector
//   last_grant  in   ID_W     index granted most recently
//   grant       out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx   out  ID_W     encoded grant index (0 when no request)
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Walk the requesters in priority order starting just after the last winner.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/arith_op_arbiter.sv
// Shares one arithmetic unit between NUM_REQ requesters with round-robin
// arbitration. A request accepted in IDLE is executed in EXEC and its result is
// presented in RESP until the consumer takes it.
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous active-high reset
//   bus    slave side of arith_op_arbiter_if (request and response handshakes)
//   busy   out  1  high whenever the FSM is not in IDLE
module arith_op_arbiter
  import arith_op_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                clk,
  input  logic                reset,
  arith_op_arbiter_if.slave   bus,
  output logic                busy
);

  state_t              state;
  logic [ID_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [2:0]          sel_op;
  logic [7:0]          sel_a;
  logic [7:0]          sel_b;
  logic [2:0]          cap_op;
  logic [7:0]          cap_a;
  logic [7:0]          cap_b;
  logic [ID_W-1:0]     cap_id;
  logic [7:0]          alu_result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // The ALU only ever sees captured operands, so requesters may change their
  // inputs freely once accepted.
  arith_op_arbiter_alu u_alu (
    .opselect (cap_op),
    .a        (cap_a),
    .b        (cap_b),
    .result   (alu_result)
  );

  // Accept strobe is only offered while idle; the arbiter output is already one-hot.
  assign bus.req_ready = (state == IDLE) ? grant : '0;

  // Operand slices of whichever requester the arbiter currently picks.
  always_comb begin
    sel_op = bus.req_op[3*int'(grant_idx) +: 3];
    sel_a  = bus.req_a [8*int'(grant_idx) +: 8];
    sel_b  = bus.req_b [8*int'(grant_idx) +: 8];
  end

  // Transaction FSM. busy and resp_valid are registered alongside the state so
  // they always describe the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= ID_W'(NUM_REQ - 1);
      cap_op          <= '0;
      cap_a           <= '0;
      cap_b           <= '0;
      cap_id          <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= '0;
      bus.resp_result <= '0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cap_op     <= sel_op;
            cap_a      <= sel_a;
            cap_b      <= sel_b;
            cap_id     <= grant_idx;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.resp_result <= alu_result;
          bus.resp_id     <= cap_id;
          bus.resp_valid  <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          bus.resp_valid <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
